// File: rtl/trace_capture_buffer.sv
// Retirement trace buffer: circular capture of PC/instr/wb/class/timestamp with a FWFT drain port.
// Optional build macro TRACE_FILTER_EN adds cfg_filter_i to select which instruction classes are stored.
module trace_capture_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       retire_valid_i,
    input  logic [XLEN-1:0]            retire_pc_i,
    input  logic [31:0]                retire_instr_i,
    input  logic [XLEN-1:0]            retire_wb_i,
    input  logic                       arm_i,
    input  logic                       cfg_wrap_i,
    input  logic                       cfg_trig_en_i,
    input  logic [XLEN-1:0]            cfg_trig_pc_i,
`ifdef TRACE_FILTER_EN
    input  logic [7:0]                 cfg_filter_i,
`endif
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [XLEN-1:0]            rd_pc_o,
    output logic [31:0]                rd_instr_o,
    output logic [XLEN-1:0]            rd_wb_o,
    output logic [2:0]                 rd_class_o,
    output logic [TS_W-1:0]            rd_ts_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic [1:0]                 state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [TS_W-1:0]   r_ts;

    logic [XLEN-1:0]   r_mem_pc    [DEPTH];
    logic [31:0]       r_mem_instr [DEPTH];
    logic [XLEN-1:0]   r_mem_wb    [DEPTH];
    logic [2:0]        r_mem_class [DEPTH];
    logic [TS_W-1:0]   r_mem_ts    [DEPTH];

    logic [2:0]        w_class;
    logic              w_pass;
    logic              w_eligible;
    logic              w_trig_hit;
    logic              w_cap_window;
    logic              w_full;
    logic              w_rd_valid;
    logic              w_pop;
    logic              w_do_cap;
    logic              w_overwrite;
    logic              w_drop;
    logic              w_fill_stop;
    logic [CW-1:0]     w_count_nxt;

    function automatic logic [2:0] f_class(input logic [6:0] op);
        case (op)
            7'b0110011: f_class = 3'd0;
            7'b0010011: f_class = 3'd1;
            7'b0000011: f_class = 3'd2;
            7'b0100011: f_class = 3'd3;
            7'b1100011: f_class = 3'd4;
            7'b0110111,
            7'b0010111: f_class = 3'd5;
            7'b1101111,
            7'b1100111: f_class = 3'd6;
            default:    f_class = 3'd7;
        endcase
    endfunction

    assign w_class = f_class(retire_instr_i[6:0]);

`ifdef TRACE_FILTER_EN
    assign w_pass = cfg_filter_i[w_class];
`else
    assign w_pass = 1'b1;
`endif

    // Trigger matching sees every retirement; the filter only decides what gets stored.
    assign w_eligible   = retire_valid_i & w_pass;
    assign w_trig_hit   = (r_state == S_ARMED) & retire_valid_i & (retire_pc_i == cfg_trig_pc_i);
    assign w_cap_window = (r_state == S_CAPTURE) | w_trig_hit;
    assign w_full       = (r_count == FULL);
    assign w_rd_valid   = (r_count != '0);
    assign w_pop        = w_rd_valid & rd_ready_i & ~arm_i;
    assign w_do_cap     = ~arm_i & w_cap_window & w_eligible & (~w_full | w_pop | cfg_wrap_i);
    assign w_overwrite  = w_do_cap & w_full & ~w_pop;
    assign w_drop       = ~arm_i & w_eligible & ((r_state == S_DONE) | (w_cap_window & ~w_do_cap));

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_cap && !w_pop && !w_full) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_do_cap) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // A pop in the same cycle as the filling capture keeps the session open.
    assign w_fill_stop = ~cfg_wrap_i & w_do_cap & ~w_pop & (w_count_nxt == FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_ts       <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (arm_i) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_state    <= cfg_trig_en_i ? S_ARMED : S_CAPTURE;
            end else begin
                if (w_do_cap) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop || w_overwrite) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_nxt;
                if (w_overwrite || w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_cap_window) begin
                    r_state <= (w_fill_stop || w_drop) ? S_DONE : S_CAPTURE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_cap) begin
            r_mem_pc[r_wr_ptr]    <= retire_pc_i;
            r_mem_instr[r_wr_ptr] <= retire_instr_i;
            r_mem_wb[r_wr_ptr]    <= retire_wb_i;
            r_mem_class[r_wr_ptr] <= w_class;
            r_mem_ts[r_wr_ptr]    <= r_ts;
        end
    end

    assign rd_valid_o = w_rd_valid;
    assign rd_pc_o    = w_rd_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign rd_instr_o = w_rd_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign rd_wb_o    = w_rd_valid ? r_mem_wb[r_rd_ptr]    : '0;
    assign rd_class_o = w_rd_valid ? r_mem_class[r_rd_ptr] : '0;
    assign rd_ts_o    = w_rd_valid ? r_mem_ts[r_rd_ptr]    : '0;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign state_o    = r_state;

endmodule
